// File: rtl/nz_dispatch_4_pkg.sv
// rtl/nz_dispatch_4_pkg.sv - shared sizes, state encoding and count helpers for nz_dispatch_4
package nz_dispatch_4_pkg;

  function automatic int c_log_2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  localparam int MAC_DIM    = 4;
  localparam int SPAD_WIDTH = 64;
  localparam int NUM_NODES  = 20;
  localparam int TAG_W      = c_log_2(NUM_NODES);
  localparam int ADDR_WIDTH = c_log_2(SPAD_WIDTH);

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  // PE count field is slots-1; an empty row still reports one (zero) slot.
  function automatic logic [1:0] nz_num(input logic [2:0] cnt);
    return (cnt == 3'd0) ? 2'd0 : 2'(cnt - 3'd1);
  endfunction

endpackage

// File: rtl/nz_prienc4.sv
// rtl/nz_prienc4.sv - picks the four lowest set bits of a mask and returns the leftover mask
module nz_prienc4
  import nz_dispatch_4_pkg::*;
(
  input  logic [SPAD_WIDTH-1:0]         i_mask,
  output logic [ADDR_WIDTH*MAC_DIM-1:0] o_addrs,
  output logic [2:0]                    o_count,
  output logic [SPAD_WIDTH-1:0]         o_mask,
  output logic                          o_last
);

  int w_n;

  always_comb begin
    w_n     = 0;
    o_addrs = '0;
    o_mask  = i_mask;
    for (int k = 0; k < SPAD_WIDTH; k++) begin
      if (i_mask[k] && (w_n < MAC_DIM)) begin
        o_addrs[w_n*ADDR_WIDTH +: ADDR_WIDTH] = ADDR_WIDTH'(k);
        o_mask[k] = 1'b0;
        w_n = w_n + 1;
      end
    end
    o_count = 3'(w_n);
  end

  // Nothing left after this beat means popcount was <= 4.
  assign o_last = (o_mask == '0);

endmodule

// File: rtl/nz_dispatch_4.sv
// rtl/nz_dispatch_4.sv - splits a non-zero bitmap row into contiguous 4-address beats for PE_4
module nz_dispatch_4
  import nz_dispatch_4_pkg::*;
(
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          bm_valid,
  output logic                          bm_ready,
  input  logic [SPAD_WIDTH-1:0]         nz_bitmap,
  input  logic [TAG_W-1:0]              tag_in,
  output logic [ADDR_WIDTH*MAC_DIM-1:0] non_zero_add_out,
  output logic [1:0]                    non_zero_num,
  output logic                          acc,
  output logic                          done,
  output logic                          beat_vd,
  output logic [TAG_W-1:0]              tag_out,
  output logic                          busy
);

  state_t                        r_state;
  logic [SPAD_WIDTH-1:0]         r_rem;
  logic [TAG_W-1:0]              r_tag;
  logic [ADDR_WIDTH*MAC_DIM-1:0] r_addrs;
  logic [1:0]                    r_num;
  logic                          r_acc;
  logic                          r_done;
  logic                          r_vd;

  logic                          w_accept;
  logic [SPAD_WIDTH-1:0]         w_src;
  logic [ADDR_WIDTH*MAC_DIM-1:0] w_addrs;
  logic [2:0]                    w_count;
  logic [SPAD_WIDTH-1:0]         w_mask;
  logic                          w_last;

  // A new row can enter while the beat on the outputs is the last of its row.
  assign bm_ready = reset && ((r_state == IDLE) || r_done);
  assign w_accept = bm_valid && bm_ready;
  assign w_src    = w_accept ? nz_bitmap : r_rem;

  nz_prienc4 u_prienc (
    .i_mask  (w_src),
    .o_addrs (w_addrs),
    .o_count (w_count),
    .o_mask  (w_mask),
    .o_last  (w_last)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
      r_rem   <= '0;
      r_tag   <= '0;
      r_addrs <= '0;
      r_num   <= '0;
      r_acc   <= 1'b0;
      r_done  <= 1'b0;
      r_vd    <= 1'b0;
    end else if (w_accept) begin
      r_state <= ISSUE;
      r_rem   <= w_mask;
      r_tag   <= tag_in;
      r_addrs <= w_addrs;
      r_num   <= nz_num(w_count);
      r_acc   <= 1'b0;
      r_done  <= w_last;
      r_vd    <= 1'b1;
    end else if ((r_state == ISSUE) && !r_done) begin
      r_rem   <= w_mask;
      r_addrs <= w_addrs;
      r_num   <= nz_num(w_count);
      r_acc   <= 1'b1;
      r_done  <= w_last;
      r_vd    <= 1'b1;
    end else begin
      r_state <= IDLE;
      r_rem   <= '0;
      r_addrs <= '0;
      r_num   <= '0;
      r_acc   <= 1'b0;
      r_done  <= 1'b0;
      r_vd    <= 1'b0;
    end
  end

  assign non_zero_add_out = r_addrs;
  assign non_zero_num     = r_num;
  assign acc              = r_acc;
  assign done             = r_done;
  assign beat_vd          = r_vd;
  assign tag_out          = r_tag;
  assign busy             = (r_state == ISSUE);

endmodule

// File: tb/tb_nz_dispatch_4.sv
// tb/tb_nz_dispatch_4.sv - directed self-checking bench for nz_dispatch_4
module tb_nz_dispatch_4;

  logic        clk;
  logic        reset;
  logic        bm_valid;
  logic        bm_ready;
  logic [63:0] nz_bitmap;
  logic [4:0]  tag_in;
  logic [23:0] non_zero_add_out;
  logic [1:0]  non_zero_num;
  logic        acc;
  logic        done;
  logic        beat_vd;
  logic [4:0]  tag_out;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  nz_dispatch_4 dut (
    .clk              (clk),
    .reset            (reset),
    .bm_valid         (bm_valid),
    .bm_ready         (bm_ready),
    .nz_bitmap        (nz_bitmap),
    .tag_in           (tag_in),
    .non_zero_add_out (non_zero_add_out),
    .non_zero_num     (non_zero_num),
    .acc              (acc),
    .done             (done),
    .beat_vd          (beat_vd),
    .tag_out          (tag_out),
    .busy             (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", nm, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input string nm, input int a0, input int a1, input int a2, input int a3,
                      input int num, input int e_acc, input int e_done, input int tg);
    logic [23:0] ea;
    ea = {6'(a3), 6'(a2), 6'(a1), 6'(a0)};
    chk({nm, ".addr"}, 64'(non_zero_add_out), 64'(ea));
    chk({nm, ".num"},  64'(non_zero_num), 64'(num));
    chk({nm, ".acc"},  64'(acc), 64'(e_acc));
    chk({nm, ".done"}, 64'(done), 64'(e_done));
    chk({nm, ".vd"},   64'(beat_vd), 64'd1);
    chk({nm, ".busy"}, 64'(busy), 64'd1);
    chk({nm, ".tag"},  64'(tag_out), 64'(tg));
  endtask

  task automatic idle(input string nm);
    chk({nm, ".vd"},   64'(beat_vd), 64'd0);
    chk({nm, ".acc"},  64'(acc), 64'd0);
    chk({nm, ".done"}, 64'(done), 64'd0);
    chk({nm, ".addr"}, 64'(non_zero_add_out), 64'd0);
    chk({nm, ".num"},  64'(non_zero_num), 64'd0);
    chk({nm, ".busy"}, 64'(busy), 64'd0);
  endtask

  task automatic offer(input logic [63:0] bm, input int tg);
    nz_bitmap = bm;
    tag_in    = 5'(tg);
    bm_valid  = 1'b1;
  endtask

  initial begin
    logic [63:0] bm;
    reset     = 1'b0;
    bm_valid  = 1'b0;
    nz_bitmap = '0;
    tag_in    = '0;
    tick();
    tick();
    idle("rst");
    chk("rst.ready", 64'(bm_ready), 64'd0);
    chk("rst.tag",   64'(tag_out), 64'd0);
    reset = 1'b1;
    tick();
    idle("idle0");
    chk("idle0.ready", 64'(bm_ready), 64'd1);

    // single full beat
    offer(64'hF0, 3);
    tick();
    bm_valid = 1'b0;
    beat("t1", 4, 5, 6, 7, 3, 0, 1, 3);
    chk("t1.ready", 64'(bm_ready), 64'd1);
    tick();
    idle("t1.after");
    chk("t1.taghold", 64'(tag_out), 64'd3);

    // six scattered bits -> two beats
    bm = (64'h1 << 1) | (64'h1 << 9) | (64'h1 << 17) | (64'h1 << 33) | (64'h1 << 40) | (64'h1 << 63);
    offer(bm, 7);
    tick();
    bm_valid = 1'b0;
    beat("t2.b1", 1, 9, 17, 33, 3, 0, 0, 7);
    chk("t2.b1.ready", 64'(bm_ready), 64'd0);
    tick();
    beat("t2.b2", 40, 63, 0, 0, 1, 1, 1, 7);
    tick();
    idle("t2.after");

    // zero bitmap, then lone top bit
    offer(64'h0, 1);
    tick();
    bm_valid = 1'b0;
    beat("t3.zero", 0, 0, 0, 0, 0, 0, 1, 1);
    tick();
    idle("t3.after0");
    offer(64'h8000_0000_0000_0000, 2);
    tick();
    bm_valid = 1'b0;
    beat("t3.b63", 63, 0, 0, 0, 0, 0, 1, 2);
    tick();
    idle("t3.after63");

    // back-to-back two-beat rows
    offer(64'h10F, 4);
    tick();
    beat("t4.b1", 0, 1, 2, 3, 3, 0, 0, 4);
    offer(64'h30_3C00, 5);
    tick();
    beat("t4.b2", 8, 0, 0, 0, 0, 1, 1, 4);
    chk("t4.b2.ready", 64'(bm_ready), 64'd1);
    tick();
    bm_valid = 1'b0;
    beat("t4.b3", 10, 11, 12, 13, 3, 0, 0, 5);
    tick();
    beat("t4.b4", 20, 21, 0, 0, 1, 1, 1, 5);
    tick();
    idle("t4.after");

    // all ones -> sixteen beats
    offer(64'hFFFF_FFFF_FFFF_FFFF, 9);
    tick();
    bm_valid = 1'b0;
    for (int k = 0; k < 16; k++) begin
      beat($sformatf("t5.b%0d", k + 1), 4*k, 4*k + 1, 4*k + 2, 4*k + 3, 3,
           (k > 0) ? 1 : 0, (k == 15) ? 1 : 0, 9);
      tick();
    end
    idle("t5.after");

    // reset during beat 2 of a three-beat row
    offer(64'hFFF, 6);
    tick();
    bm_valid = 1'b0;
    beat("t6.b1", 0, 1, 2, 3, 3, 0, 0, 6);
    tick();
    beat("t6.b2", 4, 5, 6, 7, 3, 1, 0, 6);
    reset = 1'b0;
    tick();
    idle("t6.rst");
    chk("t6.rst.tag",   64'(tag_out), 64'd0);
    chk("t6.rst.ready", 64'(bm_ready), 64'd0);
    reset = 1'b1;
    tick();
    idle("t6.post");
    offer(64'h24, 8);
    tick();
    bm_valid = 1'b0;
    beat("t6.new", 2, 5, 0, 0, 1, 0, 1, 8);
    tick();
    idle("t6.end");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
